// File: rtl/arith_arbiter_pkg.sv
// Shared types and encodings for the two-requester add/sub scheduler.
package arith_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic OP_ADD  = 1'b0;
  localparam logic OP_SUB  = 1'b1;
  localparam logic SEL_ADD = 1'b0;
  localparam logic SEL_SUB = 1'b1;

endpackage

// File: rtl/arith_arbiter_if.sv
// Bundle of request, datapath and response signals between clients and the scheduler.
interface arith_arbiter_if #(
  parameter int WIDTH = 8
);

  logic             req0_valid;
  logic             req0_ready;
  logic             req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic             req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [WIDTH-1:0] dp_a;
  logic [WIDTH-1:0] dp_b;
  logic             dp_sel;
  logic [WIDTH-1:0] dp_result;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  dp_result, rsp_ready,
    output req0_ready, req1_ready,
    output dp_a, dp_b, dp_sel,
    output rsp_valid, rsp_id, rsp_data, busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output dp_result, rsp_ready,
    input  req0_ready, req1_ready,
    input  dp_a, dp_b, dp_sel,
    input  rsp_valid, rsp_id, rsp_data, busy
  );

endinterface

// File: rtl/arith_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the pointer flips to the loser after every granted request.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_valid,
  input  logic       i_advance,
  output logic [1:0] o_grant
);

  logic       r_prio;
  logic [1:0] w_grant;

  // r_prio=0 favours req0 on a tie; a lone valid wins regardless.
  always_comb begin
    w_grant = 2'b00;
    case (i_valid)
      2'b01:   w_grant = 2'b01;
      2'b10:   w_grant = 2'b10;
      2'b11:   w_grant = r_prio ? 2'b10 : 2'b01;
      default: w_grant = 2'b00;
    endcase
  end

  assign o_grant = w_grant;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio <= 1'b0;
    end else if (i_advance) begin
      r_prio <= w_grant[0];
    end
  end

endmodule

// File: rtl/arith_arbiter.sv
// Schedules add/sub requests from two clients onto one shared registered datapath
// and returns each result, tagged with the requester id, on a valid/ready channel.
module arith_arbiter
  import arith_arbiter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DP_LATENCY = 1
) (
  input logic           clk,
  input logic           reset,
  arith_arbiter_if.slave io_bus
);

  localparam int               CNT_W    = (DP_LATENCY < 1) ? 1 : $clog2(DP_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DP_LATENCY);

  state_t           r_state;
  logic             r_op;
  logic             r_id;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;

  logic [1:0]       w_valid;
  logic [1:0]       w_grant;
  logic             w_advance;

  assign w_valid   = {io_bus.req1_valid, io_bus.req0_valid};
  assign w_advance = (r_state == IDLE) && (|w_valid);

  rr_arb2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .i_valid   (w_valid),
    .i_advance (w_advance),
    .o_grant   (w_grant)
  );

  assign io_bus.req0_ready = (r_state == IDLE) && w_grant[0];
  assign io_bus.req1_ready = (r_state == IDLE) && w_grant[1];

  // Operand registers feed the datapath directly so it stays quiet while idle.
  assign io_bus.dp_a      = r_a;
  assign io_bus.dp_b      = r_b;
  assign io_bus.dp_sel    = (r_op == OP_SUB) ? SEL_SUB : SEL_ADD;
  assign io_bus.rsp_valid = (r_state == RESP);
  assign io_bus.rsp_id    = r_id;
  assign io_bus.rsp_data  = r_data;
  assign io_bus.busy      = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_op    <= OP_ADD;
      r_id    <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_advance) begin
            r_id    <= w_grant[1];
            r_op    <= w_grant[1] ? io_bus.req1_op : io_bus.req0_op;
            r_a     <= w_grant[1] ? io_bus.req1_a  : io_bus.req0_a;
            r_b     <= w_grant[1] ? io_bus.req1_b  : io_bus.req0_b;
            r_cnt   <= '0;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          // The datapath result is settled on the final count of DP_LATENCY+1 cycles.
          if (r_cnt == CNT_LAST) begin
            r_data  <= io_bus.dp_result;
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (io_bus.rsp_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arith_arbiter.sv
// Directed bench for arith_arbiter: a DP_LATENCY=1 instance and a DP_LATENCY=0 instance,
// each driving a small adder/subtractor/mux model of the shared datapath.
module tb_arith_arbiter;
  import arith_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  arith_arbiter_if #(.WIDTH(8)) bus1 ();
  arith_arbiter_if #(.WIDTH(8)) bus0 ();

  arith_arbiter #(.WIDTH(8), .DP_LATENCY(1)) dut1 (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus1)
  );

  arith_arbiter #(.WIDTH(8), .DP_LATENCY(0)) dut0 (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus0)
  );

  // Datapath models: registered add/sub for latency 1, purely combinational for latency 0.
  logic [7:0] sumQ;
  logic [7:0] diffQ;
  logic [7:0] sum0;
  logic [7:0] diff0;

  always_ff @(posedge clk) begin
    sumQ  <= bus1.dp_a + bus1.dp_b;
    diffQ <= bus1.dp_a - bus1.dp_b;
  end
  assign bus1.dp_result = bus1.dp_sel ? diffQ : sumQ;

  assign sum0  = bus0.dp_a + bus0.dp_b;
  assign diff0 = bus0.dp_a - bus0.dp_b;
  assign bus0.dp_result = bus0.dp_sel ? diff0 : sum0;

  typedef struct {
    int         id;
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[6];
  int   total = 0;
  int   bad   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input int id, input logic valid, input logic op,
                               input logic [7:0] a, input logic [7:0] b);
    if (id == 0) begin
      bus1.req0_valid = valid;
      bus1.req0_op    = op;
      bus1.req0_a     = a;
      bus1.req0_b     = b;
    end else begin
      bus1.req1_valid = valid;
      bus1.req1_op    = op;
      bus1.req1_a     = a;
      bus1.req1_b     = b;
    end
  endtask

  function automatic logic readyOf(input int id);
    return (id == 0) ? bus1.req0_ready : bus1.req1_ready;
  endfunction

  // One complete operation on the latency-1 instance with rsp_ready held high.
  task automatic runOp(input string name, input int id, input logic op,
                       input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp);
    int   edges;
    logic seen;
    @(negedge clk);
    applyStimulus(id, 1'b1, op, a, b);
    #1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (readyOf(id)) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    checkOutput({name, "_grant"}, 32'(seen), 32'd1);
    if (!seen) begin
      applyStimulus(id, 1'b0, op, a, b);
      return;
    end
    @(posedge clk);
    #1;
    applyStimulus(id, 1'b0, op, a, b);
    edges = 1;
    @(negedge clk);
    checkOutput({name, "_dpsel"}, 32'(bus1.dp_sel), 32'((op == OP_SUB) ? SEL_SUB : SEL_ADD));
    for (int i = 0; i < 20; i++) begin
      if (bus1.rsp_valid) break;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    checkOutput({name, "_latency"}, 32'(edges), 32'd3);
    checkOutput({name, "_data"}, 32'(bus1.rsp_data), 32'(exp));
    checkOutput({name, "_id"}, 32'(bus1.rsp_id), 32'(id));
    @(posedge clk);
    @(negedge clk);
    checkOutput({name, "_idle"}, 32'({bus1.busy, bus1.rsp_valid}), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   edges;
    int   ghosts;
    logic seen;

    vecs[0] = '{0, OP_ADD, 8'h12, 8'h34, 8'h46};
    vecs[1] = '{1, OP_SUB, 8'h05, 8'h07, 8'hFE};
    vecs[2] = '{0, OP_ADD, 8'hF0, 8'h20, 8'h10};
    vecs[3] = '{1, OP_ADD, 8'hFF, 8'h01, 8'h00};
    vecs[4] = '{0, OP_SUB, 8'h00, 8'h01, 8'hFF};
    vecs[5] = '{1, OP_SUB, 8'h80, 8'h01, 8'h7F};

    reset = 1'b1;
    applyStimulus(0, 1'b0, OP_ADD, 8'h00, 8'h00);
    applyStimulus(1, 1'b0, OP_ADD, 8'h00, 8'h00);
    bus1.rsp_ready  = 1'b1;
    bus0.req0_valid = 1'b0;
    bus0.req0_op    = OP_ADD;
    bus0.req0_a     = 8'h00;
    bus0.req0_b     = 8'h00;
    bus0.req1_valid = 1'b0;
    bus0.req1_op    = OP_ADD;
    bus0.req1_a     = 8'h00;
    bus0.req1_b     = 8'h00;
    bus0.rsp_ready  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;

    checkOutput("rst_ready",    32'({bus1.req1_ready, bus1.req0_ready}), 32'd0);
    checkOutput("rst_rspvalid", 32'(bus1.rsp_valid), 32'd0);
    checkOutput("rst_rspid",    32'(bus1.rsp_id), 32'd0);
    checkOutput("rst_rspdata",  32'(bus1.rsp_data), 32'd0);
    checkOutput("rst_dpa",      32'(bus1.dp_a), 32'd0);
    checkOutput("rst_dpb",      32'(bus1.dp_b), 32'd0);
    checkOutput("rst_dpsel",    32'(bus1.dp_sel), 32'd0);
    checkOutput("rst_busy",     32'({bus1.busy, bus0.busy}), 32'd0);

    for (int i = 0; i < 6; i++) begin
      runOp($sformatf("vec%0d", i), vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
    end

    // Both requesters held valid: grants and response ids must alternate 0,1,0,1.
    @(negedge clk);
    applyStimulus(0, 1'b1, OP_ADD, 8'h01, 8'h02);
    applyStimulus(1, 1'b1, OP_SUB, 8'h09, 8'h04);
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput($sformatf("fair%0d_grant", k), 32'({bus1.req1_ready, bus1.req0_ready}),
                  (k % 2 == 1) ? 32'd2 : 32'd1);
      @(posedge clk);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (bus1.rsp_valid) begin
          seen = 1'b1;
          break;
        end
      end
      checkOutput($sformatf("fair%0d_seen", k), 32'(seen), 32'd1);
      checkOutput($sformatf("fair%0d_id", k), 32'(bus1.rsp_id), 32'(k % 2));
      checkOutput($sformatf("fair%0d_data", k), 32'(bus1.rsp_data),
                  (k % 2 == 1) ? 32'h05 : 32'h03);
      @(posedge clk);
      @(negedge clk);
    end
    applyStimulus(0, 1'b0, OP_ADD, 8'h00, 8'h00);
    applyStimulus(1, 1'b0, OP_ADD, 8'h00, 8'h00);

    // Response backpressure for five cycles while req0 is also asking.
    @(negedge clk);
    bus1.rsp_ready = 1'b0;
    applyStimulus(1, 1'b1, OP_ADD, 8'h33, 8'h44);
    #1;
    checkOutput("bp_grant", 32'(bus1.req1_ready), 32'd1);
    @(posedge clk);
    #1;
    applyStimulus(1, 1'b0, OP_ADD, 8'h33, 8'h44);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus1.rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("bp_seen", 32'(seen), 32'd1);
    applyStimulus(0, 1'b1, OP_ADD, 8'h11, 8'h11);
    for (int c = 0; c < 5; c++) begin
      #1;
      checkOutput($sformatf("bp_hold%0d", c),
                  32'({bus1.rsp_valid, bus1.rsp_id, bus1.rsp_data,
                       bus1.req0_ready, bus1.req1_ready, bus1.busy}),
                  32'({1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1}));
      @(negedge clk);
    end
    applyStimulus(0, 1'b0, OP_ADD, 8'h00, 8'h00);
    bus1.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp_release",
                32'({bus1.busy, bus1.rsp_valid, bus1.req0_ready, bus1.req1_ready}), 32'd0);

    // Reset during WAIT discards the req1 operation entirely.
    @(negedge clk);
    applyStimulus(1, 1'b1, OP_SUB, 8'h50, 8'h10);
    #1;
    checkOutput("rstw_grant", 32'(bus1.req1_ready), 32'd1);
    @(posedge clk);
    #1;
    applyStimulus(1, 1'b0, OP_SUB, 8'h50, 8'h10);
    @(negedge clk);
    checkOutput("rstw_inwait", 32'({bus1.busy, bus1.dp_sel, bus1.dp_a}), 32'({1'b1, 1'b1, 8'h50}));
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rstw_cleared",
                32'({bus1.busy, bus1.rsp_valid, bus1.dp_sel, bus1.dp_a, bus1.dp_b, bus1.rsp_data}),
                32'd0);
    @(negedge clk);
    reset = 1'b0;
    ghosts = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus1.rsp_valid) ghosts++;
    end
    checkOutput("rstw_noghost", 32'(ghosts), 32'd0);
    applyStimulus(0, 1'b1, OP_ADD, 8'h01, 8'h02);
    applyStimulus(1, 1'b1, OP_SUB, 8'h09, 8'h04);
    #1;
    checkOutput("rstw_prio", 32'({bus1.req1_ready, bus1.req0_ready}), 32'd1);
    @(posedge clk);
    #1;
    applyStimulus(0, 1'b0, OP_ADD, 8'h00, 8'h00);
    applyStimulus(1, 1'b0, OP_ADD, 8'h00, 8'h00);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus1.rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("rstw_rsp", 32'({seen, bus1.rsp_id, bus1.rsp_data}), 32'({1'b1, 1'b0, 8'h03}));
    @(posedge clk);
    @(negedge clk);

    // Combinational datapath build: response two edges after the handshake.
    bus0.req0_valid = 1'b1;
    bus0.req0_op    = OP_ADD;
    bus0.req0_a     = 8'h01;
    bus0.req0_b     = 8'h01;
    #1;
    checkOutput("lat0_grant", 32'(bus0.req0_ready), 32'd1);
    @(posedge clk);
    #1;
    bus0.req0_valid = 1'b0;
    edges = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus0.rsp_valid) break;
      @(posedge clk);
      edges++;
    end
    checkOutput("lat0_latency", 32'(edges), 32'd2);
    checkOutput("lat0_data", 32'(bus0.rsp_data), 32'h02);
    checkOutput("lat0_id", 32'(bus0.rsp_id), 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("lat0_idle", 32'({bus0.busy, bus0.rsp_valid}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arith_arbiter.md
# arith_arbiter

Two-requester scheduler that shares the single registered Adder/Subtractor datapath (selected through the result mux) between independent clients. It accepts add/sub operations over valid/ready handshakes and arbitrates round-robin. It drives operands and the mux select into the shared datapath, waits the datapath's fixed latency, then returns the captured result with the requester's id over a valid/ready response channel. It sits between client logic and the existing adder/subtractor/mux datapath.

## Interface
Parameters:
- WIDTH, 8, operand/result width
- DP_LATENCY, 1, datapath cycles from stable operands to valid result (0 = combinational)

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state
- req0_valid / req1_valid  in  1  requester has an operation pending
- req0_ready / req1_ready  out  1  grant; handshake when valid&ready
- req0_op / req1_op  in  1  0 = ADD, 1 = SUB (a - b)
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- dp_a, dp_b  out  WIDTH  operands to shared adder and subtractor
- dp_sel  out  1  mux select: 0 = adder output, 1 = subtractor output
- dp_result  in  WIDTH  mux output from datapath
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  requester that issued the operation
- rsp_data  out  WIDTH  captured result
- busy  out  1  high in any state except IDLE

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req*_ready is combinational: high only for the arbitration winner among asserted valids.
  - On handshake, capture op/a/b/id into operand registers and go to WAIT.
  - With no valid, remain in IDLE with both readys low.
- Arbitration:
  - Two-way round-robin with a 1-bit priority pointer; reset value favours req0.
  - After a grant to N, priority moves to the other requester.
  - A lone valid always wins, regardless of the pointer.
- WAIT:
  - dp_a, dp_b and dp_sel are driven from the operand registers and held stable.
  - A wait counter runs DP_LATENCY+1 cycles.
  - On the last WAIT cycle, dp_result is captured into rsp_data and the FSM goes to RESP.
- RESP:
  - rsp_valid is high; rsp_id and rsp_data are held.
  - On rsp_valid&rsp_ready, go to IDLE.
  - Backpressure stalls indefinitely; both readys stay low.
- Arithmetic is performed by the datapath, modulo 2^WIDTH: add wraps, sub wraps (two's complement). The controller passes the result unmodified.
- Operand registers hold their last value in IDLE, so dp_* do not toggle when idle.

## Timing
- Reset values: state=IDLE; all readys=0; rsp_valid=0; rsp_id=0; rsp_data=0; dp_a=0; dp_b=0; dp_sel=0; busy=0; pointer=req0; counter=0.
- Request handshake at edge T → WAIT during cycles T+1 … T+DP_LATENCY+1 → rsp_valid first high in cycle T+DP_LATENCY+2.
- With rsp_ready held high, sustained throughput is one operation per DP_LATENCY+3 cycles. There is one IDLE cycle between operations; no overlap.
- Both valids in the same IDLE cycle: exactly one ready asserted, per the pointer.
- A requester that drops valid before ready has no effect and needs no recovery.
- Reset asserted in any state: the in-flight operation is discarded and no response is produced. The next cycle is IDLE with reset values.
- rsp_ready is ignored while rsp_valid is low.

## Structure
- Package arith_arbiter_pkg:
  - state enum (IDLE, WAIT, RESP)
  - op constants OP_ADD=1'b0, OP_SUB=1'b1
  - dp_sel constants SEL_ADD=1'b0, SEL_SUB=1'b1
- Sub-module rr_arb2: two-way round-robin arbiter.
  - Inputs: valid pair and an advance strobe.
  - Outputs: one-hot grant; owns the priority pointer.
- Top contains the FSM, operand/id/result registers and the wait counter.
- Bench model: registered adder/subtractor with latency DP_LATENCY feeding a mux on dp_sel.

## Test plan
- Single ADD, DP_LATENCY=1: req0 a=8'h12 b=8'h34, rsp_ready=1 → rsp_valid exactly 3 cycles after handshake, rsp_data=8'h46, rsp_id=0.
- Wrap cases:
  - SUB a=8'h05 b=8'h07 → rsp_data=8'hFE.
  - ADD a=8'hF0 b=8'h20 → rsp_data=8'h10.
  - dp_sel=1 during the SUB's WAIT.
- Fairness: both valids held, 4 ops → grants alternate 0,1,0,1; rsp_id follows the same sequence.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_valid/rsp_data/rsp_id stable, req*_ready=0, busy=1; release → IDLE next cycle.
- Reset mid-WAIT on a req1 op → next cycle IDLE, rsp_valid=0, and no response for that op ever appears. A subsequent simultaneous request is granted to req0.
- DP_LATENCY=0 build: ADD 8'h01+8'h01 → rsp_valid 2 cycles after handshake, rsp_data=8'h02.
